bridge_sequencer: RTL and testbench

- Central controller of the AXI2APB bridge; sequences the AXI read unit, AXI write unit and the single APB master through complete bursts.
- Arbitrates between pending AXI read and write transactions for the shared APB port, using round-robin on conflict.
- Drives the rd_cmd_t, wr_cmd_t and apb_cmd_t commands and consumes the matching *_info_t status from the bridge_utils package.
- Contains a per-state watchdog that aborts a hung handshake.

---
 rtl/bridge_sequencer_pkg.sv | 25 ++
 rtl/bridge_sequencer_arb.sv | 26 ++
 rtl/bridge_sequencer.sv | 140 ++++++++++++++
 tb/tb_bridge_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_sequencer_pkg.sv
// Shared AXI2APB bridge types: unit command/status encodings and sequencer states.
package bridge_utils;

  typedef enum logic [1:0] {R_DISABLE, R_GET_ADDR_DATA, R_GET_RESP} rd_cmd_t;
  typedef enum logic [1:0] {R_IDLE, R_BUSY, R_SWITCH} rd_info_t;
  typedef enum logic [1:0] {W_DISABLE, W_GET_ADDR, W_GET_DATA} wr_cmd_t;
  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_SWITCH} wr_info_t;
  typedef enum logic [1:0] {APB_DISABLE, APB_READ, APB_WRITE} apb_cmd_t;
  typedef enum logic [1:0] {APB_IDLE, APB_BUSY, APB_SWITCH} apb_info_t;

  // Legacy-compatible fixed state encodings.
  typedef logic [3:0] seq_state_t;
  localparam seq_state_t IDLE    = 4'd0;
  localparam seq_state_t RD_ADDR = 4'd1;
  localparam seq_state_t RD_APB  = 4'd2;
  localparam seq_state_t RD_BEAT = 4'd3;
  localparam seq_state_t RD_DONE = 4'd4;
  localparam seq_state_t WR_ADDR = 4'd5;
  localparam seq_state_t WR_DATA = 4'd6;
  localparam seq_state_t WR_APB  = 4'd7;
  localparam seq_state_t WR_DONE = 4'd8;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/bridge_sequencer_arb.sv
// Two-requester round-robin arbiter; grant_write remembers the last winner.
module seq_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic req_rd,
  input  logic req_wr,
  output logic grant,
  output logic grant_wr,
  output logic grant_write
);

  always_comb begin
    grant    = enable && (req_rd || req_wr);
    grant_wr = req_wr && (!req_rd || !grant_write);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_write <= 1'b1;
    end else if (grant) begin
      grant_write <= grant_wr;
    end
  end

endmodule

// File: rtl/bridge_sequencer.sv
// AXI2APB bridge controller: sequences read/write units and the APB master through bursts.
module bridge_sequencer
  import bridge_utils::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ar_pending,
  input  logic       aw_pending,
  input  rd_info_t   rd_info,
  input  wr_info_t   wr_info,
  input  apb_info_t  apb_info,
  input  logic [3:0] rd_len,
  input  logic [3:0] wr_len,
  output rd_cmd_t    rd_cmd,
  output wr_cmd_t    wr_cmd,
  output apb_cmd_t   apb_cmd,
  output logic [3:0] beat_idx,
  output logic       last_beat,
  output logic       grant_write,
  output logic       busy,
  output logic       timeout_err
);

  seq_state_t          state, nstate;
  logic [TO_WIDTH-1:0] wd;
  logic [3:0]          len, len_n, beat_n;
  logic                abort, at_last, in_burst_n;
  logic                arb_grant, arb_grant_wr;
  rd_cmd_t             rd_cmd_n;
  wr_cmd_t             wr_cmd_n;
  apb_cmd_t            apb_cmd_n;

  seq_rr_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .enable      (state == IDLE),
    .req_rd      (ar_pending),
    .req_wr      (aw_pending),
    .grant       (arb_grant),
    .grant_wr    (arb_grant_wr),
    .grant_write (grant_write)
  );

  always_comb begin
    nstate  = state;
    len_n   = len;
    beat_n  = beat_idx;
    abort   = 1'b0;
    at_last = (beat_idx == len);
    case (state)
      IDLE:    if (arb_grant) nstate = arb_grant_wr ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (rd_info == R_SWITCH) begin
                 nstate = RD_APB;
                 len_n  = rd_len;
                 beat_n = '0;
               end
      RD_APB:  if (apb_info == APB_SWITCH) nstate = RD_BEAT;
      RD_BEAT: if (rd_info == R_SWITCH) begin
                 if (at_last) begin
                   nstate = RD_DONE;
                 end else begin
                   nstate = RD_APB;
                   beat_n = beat_idx + 4'd1;
                 end
               end
      RD_DONE: if (rd_info == R_IDLE) nstate = IDLE;
      WR_ADDR: if (wr_info == W_SWITCH) begin
                 nstate = WR_DATA;
                 len_n  = wr_len;
                 beat_n = '0;
               end
      WR_DATA: if (wr_info == W_SWITCH) nstate = WR_APB;
      WR_APB:  if (apb_info == APB_SWITCH) begin
                 if (at_last) begin
                   nstate = WR_DONE;
                 end else begin
                   nstate = WR_DATA;
                   beat_n = beat_idx + 4'd1;
                 end
               end
      WR_DONE: if (wr_info == W_IDLE) nstate = IDLE;
      default: nstate = IDLE;
    endcase
    // A status arriving on the final watchdog cycle has already moved nstate, so it wins.
    if (state != IDLE && nstate == state && wd == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
      abort  = 1'b1;
      nstate = IDLE;
    end
  end

  always_comb begin
    rd_cmd_n   = R_DISABLE;
    wr_cmd_n   = W_DISABLE;
    apb_cmd_n  = APB_DISABLE;
    in_burst_n = 1'b0;
    case (nstate)
      RD_ADDR: rd_cmd_n = R_GET_ADDR_DATA;
      RD_APB:  begin apb_cmd_n = APB_READ;  in_burst_n = 1'b1; end
      RD_BEAT: begin rd_cmd_n = R_GET_RESP; in_burst_n = 1'b1; end
      RD_DONE: in_burst_n = 1'b1;
      WR_ADDR: wr_cmd_n = W_GET_ADDR;
      WR_DATA: begin wr_cmd_n = W_GET_DATA; in_burst_n = 1'b1; end
      WR_APB:  begin apb_cmd_n = APB_WRITE; in_burst_n = 1'b1; end
      WR_DONE: in_burst_n = 1'b1;
      default: ;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wd          <= '0;
      len         <= '0;
      beat_idx    <= '0;
      last_beat   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      rd_cmd      <= R_DISABLE;
      wr_cmd      <= W_DISABLE;
      apb_cmd     <= APB_DISABLE;
    end else begin
      state       <= nstate;
      if (nstate != state || state == IDLE) wd <= '0;
      else                                  wd <= wd + 1'b1;
      len         <= len_n;
      beat_idx    <= beat_n;
      last_beat   <= in_burst_n && (beat_n == len_n);
      busy        <= (nstate != IDLE);
      timeout_err <= abort;
      rd_cmd      <= rd_cmd_n;
      wr_cmd      <= wr_cmd_n;
      apb_cmd     <= apb_cmd_n;
    end
  end

endmodule

// File: tb/tb_bridge_sequencer.sv
// Directed bench for bridge_sequencer with a short watchdog (TIMEOUT_CYCLES=8).
module tb_bridge_sequencer;
  import bridge_utils::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ar_pending, aw_pending;
  rd_info_t   rd_info;
  wr_info_t   wr_info;
  apb_info_t  apb_info;
  logic [3:0] rd_len, wr_len;
  rd_cmd_t    rd_cmd;
  wr_cmd_t    wr_cmd;
  apb_cmd_t   apb_cmd;
  logic [3:0] beat_idx;
  logic       last_beat, grant_write, busy, timeout_err;

  int tests = 0;
  int fails = 0;

  bridge_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ar_pending  (ar_pending),
    .aw_pending  (aw_pending),
    .rd_info     (rd_info),
    .wr_info     (wr_info),
    .apb_info    (apb_info),
    .rd_len      (rd_len),
    .wr_len      (wr_len),
    .rd_cmd      (rd_cmd),
    .wr_cmd      (wr_cmd),
    .apb_cmd     (apb_cmd),
    .beat_idx    (beat_idx),
    .last_beat   (last_beat),
    .grant_write (grant_write),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_disabled(input string tag);
    check({tag, ".rd_cmd"},  rd_cmd,  R_DISABLE);
    check({tag, ".wr_cmd"},  wr_cmd,  W_DISABLE);
    check({tag, ".apb_cmd"}, apb_cmd, APB_DISABLE);
  endtask

  // Entered just after the edge into RD_APB for beat b; leaves just after the next RD_APB/RD_DONE edge.
  task automatic read_beat(input int b, input logic [3:0] len);
    string t;
    t = $sformatf("rd_apb[%0d]", b);
    check({t, ".apb"},  apb_cmd,   APB_READ);
    check({t, ".rd"},   rd_cmd,    R_DISABLE);
    check({t, ".beat"}, beat_idx,  b);
    check({t, ".last"}, last_beat, (b == int'(len)));
    step();
    apb_info = APB_SWITCH;
    step();
    apb_info = APB_IDLE;
    t = $sformatf("rd_beat[%0d]", b);
    check({t, ".rd"},   rd_cmd,   R_GET_RESP);
    check({t, ".apb"},  apb_cmd,  APB_DISABLE);
    check({t, ".beat"}, beat_idx, b);
    step();
    rd_info = R_SWITCH;
    step();
    rd_info = R_BUSY;
  endtask

  // Entered just after the edge into RD_ADDR; leaves just after the edge back into IDLE.
  task automatic run_read(input logic [3:0] len);
    check("rd_addr.rd", rd_cmd, R_GET_ADDR_DATA);
    check("rd_addr.busy", busy, 1'b1);
    step();
    rd_len  = len;
    rd_info = R_SWITCH;
    step();
    rd_info = R_BUSY;
    for (int b = 0; b <= int'(len); b++) read_beat(b, len);
    check_all_disabled("rd_done");
    check("rd_done.beat", beat_idx, len);
    check("rd_done.busy", busy, 1'b1);
    rd_info = R_IDLE;
    step();
    check("rd_end.busy", busy, 1'b0);
    check_all_disabled("rd_end");
  endtask

  // Entered just after the edge into WR_DATA for beat b; leaves after the next WR_DATA/WR_DONE edge.
  task automatic write_beat(input int b, input logic [3:0] len);
    string t;
    t = $sformatf("wr_data[%0d]", b);
    check({t, ".wr"},   wr_cmd,    W_GET_DATA);
    check({t, ".apb"},  apb_cmd,   APB_DISABLE);
    check({t, ".beat"}, beat_idx,  b);
    check({t, ".last"}, last_beat, (b == int'(len)));
    step();
    wr_info = W_SWITCH;
    step();
    wr_info = W_BUSY;
    t = $sformatf("wr_apb[%0d]", b);
    check({t, ".apb"},  apb_cmd,  APB_WRITE);
    check({t, ".wr"},   wr_cmd,   W_DISABLE);
    check({t, ".beat"}, beat_idx, b);
    step();
    apb_info = APB_SWITCH;
    step();
    apb_info = APB_IDLE;
  endtask

  task automatic write_addr(input logic [3:0] len);
    check("wr_addr.wr", wr_cmd, W_GET_ADDR);
    check("wr_addr.busy", busy, 1'b1);
    step();
    wr_len  = len;
    wr_info = W_SWITCH;
    step();
    wr_info = W_BUSY;
  endtask

  task automatic run_write(input logic [3:0] len);
    write_addr(len);
    for (int b = 0; b <= int'(len); b++) write_beat(b, len);
    check_all_disabled("wr_done");
    check("wr_done.busy", busy, 1'b1);
    check("wr_done.beat", beat_idx, len);
    wr_info = W_IDLE;
    step();
    check("wr_end.busy", busy, 1'b0);
    check_all_disabled("wr_end");
  endtask

  initial begin
    rst = 1'b1; ar_pending = 1'b0; aw_pending = 1'b0;
    rd_info = R_IDLE; wr_info = W_IDLE; apb_info = APB_IDLE;
    rd_len = '0; wr_len = '0;
    step(); step();
    check_all_disabled("reset");
    check("reset.beat", beat_idx, 4'd0);
    check("reset.last", last_beat, 1'b0);
    check("reset.gw", grant_write, 1'b1);
    check("reset.busy", busy, 1'b0);
    check("reset.to", timeout_err, 1'b0);
    rst = 1'b0;
    step();
    check("idle.busy", busy, 1'b0);

    // Single read, len 0
    ar_pending = 1'b1;
    step();
    ar_pending = 1'b0;
    check("single_rd.gw", grant_write, 1'b0);
    run_read(4'd0);

    // Write burst, len 3
    aw_pending = 1'b1;
    step();
    aw_pending = 1'b0;
    check("wr_burst.gw", grant_write, 1'b1);
    run_write(4'd3);

    // Both pending held high: read, write, read, write
    ar_pending = 1'b1; aw_pending = 1'b1;
    step();
    check("arb0.gw", grant_write, 1'b0);
    check("arb0.wr", wr_cmd, W_DISABLE);
    run_read(4'd0);
    step();
    check("arb1.gw", grant_write, 1'b1);
    check("arb1.rd", rd_cmd, R_DISABLE);
    run_write(4'd0);
    step();
    check("arb2.gw", grant_write, 1'b0);
    run_read(4'd1);
    step();
    check("arb3.gw", grant_write, 1'b1);
    ar_pending = 1'b0; aw_pending = 1'b0;
    run_write(4'd0);

    // Maximum length read
    ar_pending = 1'b1;
    step();
    ar_pending = 1'b0;
    run_read(4'd15);

    // Watchdog abort in RD_APB
    ar_pending = 1'b1;
    step();
    ar_pending = 1'b0;
    check("to.rd_addr", rd_cmd, R_GET_ADDR_DATA);
    step();
    rd_len = 4'd0; rd_info = R_SWITCH;
    step();
    rd_info = R_BUSY; apb_info = APB_BUSY;
    for (int i = 1; i <= 7; i++) step();
    check("to.pre_apb", apb_cmd, APB_READ);
    check("to.pre_err", timeout_err, 1'b0);
    step();
    check("to.err", timeout_err, 1'b1);
    check_all_disabled("to.abort");
    check("to.busy", busy, 1'b0);
    check("to.gw", grant_write, 1'b0);
    step();
    check("to.pulse_end", timeout_err, 1'b0);
    check("to.idle_busy", busy, 1'b0);

    // Status on the last watchdog cycle wins
    apb_info = APB_IDLE; rd_info = R_IDLE;
    ar_pending = 1'b1;
    step();
    ar_pending = 1'b0;
    step();
    rd_info = R_SWITCH;
    step();
    rd_info = R_BUSY; apb_info = APB_BUSY;
    for (int i = 1; i <= 7; i++) step();
    apb_info = APB_SWITCH;
    step();
    apb_info = APB_IDLE;
    check("coin.err", timeout_err, 1'b0);
    check("coin.rd", rd_cmd, R_GET_RESP);
    check("coin.busy", busy, 1'b1);
    rd_info = R_SWITCH;
    step();
    rd_info = R_IDLE;
    step();
    check("coin.end_busy", busy, 1'b0);

    // Reset during WR_APB at beat 2 of len 7, then restart
    aw_pending = 1'b1;
    step();
    aw_pending = 1'b0;
    write_addr(4'd7);
    write_beat(0, 4'd7);
    write_beat(1, 4'd7);
    check("mid.beat2_data", wr_cmd, W_GET_DATA);
    step();
    wr_info = W_SWITCH;
    step();
    wr_info = W_BUSY;
    check("mid.apb", apb_cmd, APB_WRITE);
    check("mid.beat", beat_idx, 4'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_info = W_IDLE;
    check_all_disabled("mid.rst");
    check("mid.rst_beat", beat_idx, 4'd0);
    check("mid.rst_busy", busy, 1'b0);
    check("mid.rst_last", last_beat, 1'b0);
    aw_pending = 1'b1;
    step();
    aw_pending = 1'b0;
    run_write(4'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
